// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/bubble control for a 5-stage in-order core: load-use stalls,
// branch squash, HLT drain, memory-wait freeze with timeout, stall counter.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        halt_ex,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_bubble,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              memstall;
  logic              timeout;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign memstall = mem_req & ~mem_ack;
  assign timeout  = memstall && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    case (state)
      RUN, MEMWAIT: begin
        if (memstall) begin
          // Whole pipeline frozen; all enables stay at their 0 defaults.
          wait_nxt  = wait_cnt + 1'b1;
          state_nxt = timeout ? HALT : MEMWAIT;
        end else begin
          wait_nxt = '0;
          if (halt_ex) begin
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            state_nxt   = HALT;
          end else if (branch_taken) begin
            // Wins over hazard: the stalled instruction is wrong-path anyway.
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            state_nxt   = RUN;
          end else if (hazard) begin
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            state_nxt   = RUN;
          end else begin
            pc_we     = 1'b1;
            ifid_we   = 1'b1;
            idex_we   = 1'b1;
            exmem_we  = 1'b1;
            memwb_we  = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      HALT: begin
        state_nxt = HALT;
        wait_nxt  = '0;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_we     = 1'b0;
      idex_bubble = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halted    <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == HALT)
        halted <= 1'b1;
      if (state != HALT && timeout)
        mem_err <= 1'b1;
      if (!pc_we && state != HALT)
        stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios with literal checks plus a
// per-cycle comparison against a rule-table model of the control outputs.
module tb_pipeline_stall_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0, branch_taken = 1'b0, halt_ex = 1'b0;
  logic        mem_req = 1'b0, mem_ack = 1'b0;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
  logic        halted, mem_err;
  logic [15:0] stall_cnt;
  logic [6:0]  outs;

  int n_chk  = 0;
  int n_fail = 0;

  bit m_halted = 1'b0;
  bit m_err    = 1'b0;
  int m_wait   = 0;
  int m_stall  = 0;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(TO), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .halt_ex(halt_ex), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we};

  // Order: pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we
  function automatic logic [6:0] rule_outs(input bit h, hz, br, hx, req, ack);
    if (h || (req && !ack)) return 7'b0000000;
    if (hx) return 7'b0111111;
    if (br) return 7'b1111111;
    if (hz) return 7'b0001111;
    return 7'b1101011;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input bit hz, br, hx, req, ack);
    hazard = hz; branch_taken = br; halt_ex = hx; mem_req = req; mem_ack = ack;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
  endtask

  // Model + per-cycle compare
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_halted = 0; m_err = 0; m_wait = 0; m_stall = 0;
        chk("m_outs_rst", {25'd0, outs}, 32'd0);
      end else begin
        e = rule_outs(m_halted, hazard, branch_taken, halt_ex, mem_req, mem_ack);
        chk("m_outs", {25'd0, outs}, {25'd0, e});
      end
      chk("m_halted", {31'd0, halted}, {31'd0, m_halted});
      chk("m_mem_err", {31'd0, mem_err}, {31'd0, m_err});
      chk("m_stall_cnt", {16'd0, stall_cnt}, m_stall);
      @(posedge clk);
      if (rst) begin
        m_halted = 0; m_err = 0; m_wait = 0; m_stall = 0;
      end else if (!m_halted) begin
        e = rule_outs(0, hazard, branch_taken, halt_ex, mem_req, mem_ack);
        if (!e[6] && m_stall < 65535) m_stall++;
        if (mem_req && !mem_ack) begin
          if (m_wait + 1 == TO) begin
            m_halted = 1; m_err = 1;
          end else m_wait++;
        end else begin
          m_wait = 0;
          if (halt_ex) m_halted = 1;
        end
      end
    end
  end

  // Directed scenarios with literal expectations
  initial begin
    @(negedge clk);
    chk("rst_outs", {25'd0, outs}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single-cycle load-use hazard
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("hz_outs", {25'd0, outs}, 32'b0001111);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("hz_after_outs", {25'd0, outs}, 32'b1101011);
    chk("hz_stall", {16'd0, stall_cnt}, 32'd1);

    // Branch overrides hazard
    do_reset();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    chk("br_outs", {25'd0, outs}, 32'b1111111);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("br_stall", {16'd0, stall_cnt}, 32'd0);

    // Single-cycle memory: no stall
    do_reset();
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("mem1_outs", {25'd0, outs}, 32'b1101011);

    // Three wait cycles then ack
    do_reset();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_frozen", {25'd0, outs}, 32'd0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("mw_ack_outs", {25'd0, outs}, 32'b1101011);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_stall", {16'd0, stall_cnt}, 32'd3);
    chk("mw_err", {31'd0, mem_err}, 32'd0);
    chk("mw_halted", {31'd0, halted}, 32'd0);
    chk("mw_run_outs", {25'd0, outs}, 32'b1101011);

    // Memory timeout
    do_reset();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_frozen", {25'd0, outs}, 32'd0);
      chk("to_not_halted", {31'd0, halted}, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_halted", {31'd0, halted}, 32'd1);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_stall", {16'd0, stall_cnt}, 32'd4);
    next_cycle();
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("to_ack_ignored", {25'd0, outs}, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0);

    // HLT together with hazard, then sticky halt
    do_reset();
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    chk("hlt_outs", {25'd0, outs}, 32'b0111111);
    next_cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hlt_halted", {31'd0, halted}, 32'd1);
      chk("hlt_frozen", {25'd0, outs}, 32'd0);
      next_cycle();
      drive(0, 1, 0, 0, 0);
    end
    @(negedge clk);
    chk("hlt_stall", {16'd0, stall_cnt}, 32'd1);
    chk("hlt_err", {31'd0, mem_err}, 32'd0);

    // Saturation and asynchronous clear
    do_reset();
    drive(1, 0, 0, 0, 0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_stall", {16'd0, stall_cnt}, 32'h0000FFFF);
    #1 rst = 1'b1;
    #1;
    chk("async_clr_stall", {16'd0, stall_cnt}, 32'd0);
    chk("async_clr_outs", {25'd0, outs}, 32'd0);
    drive(0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", {25'd0, outs}, 32'b1101011);
    chk("post_rst_stall", {16'd0, stall_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
